esl_fault_filter: RTL and testbench

Downstream consumer of the complementary-input checker. It takes the per-bit check vector and the aggregate fault flag and filters transient discrepancies with a persistence counter. A persistent fault is latched into a safe state, and a controlled, time-qualified recovery sequence releases it. It also reports fault statistics: a saturating count of fault entries and the failing-bit bitmap captured at each entry.

---
 rtl/esl_fault_filter_if.sv | 25 ++
 rtl/esl_fault_filter.sv | 123 ++++++++++++
 tb/tb_esl_fault_filter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/esl_fault_filter_if.sv
// Bus between the complementary-input checker side and esl_fault_filter:
// check/fault inputs toward the filter, state and statistics back out.
interface esl_fault_filter_if #(
  parameter int P_DATA_WIDTH = 7,
  parameter int P_CNT_WIDTH  = 8
);
  logic [P_DATA_WIDTH-1:0] check_ok;
  logic                    fault_in;
  logic                    fault_clr;
  logic                    safe_ok;
  logic                    fault_latched;
  logic [1:0]              state;
  logic [P_DATA_WIDTH-1:0] fault_bits;
  logic [P_CNT_WIDTH-1:0]  fault_count;

  modport master (
    output check_ok, fault_in, fault_clr,
    input  safe_ok, fault_latched, state, fault_bits, fault_count
  );

  modport slave (
    input  check_ok, fault_in, fault_clr,
    output safe_ok, fault_latched, state, fault_bits, fault_count
  );
endinterface

// File: rtl/esl_fault_filter.sv
// Persistence filter and safe-state latch for the upstream fault flag, with fault statistics.
// Optional ESL_FAULT_AUTO_RECOVER_EN: leave FAULTED on any clean sample, without fault_clr.
module esl_fault_filter #(
  parameter int P_DATA_WIDTH     = 7,
  parameter int P_FILTER_CYCLES  = 4,
  parameter int P_RECOVER_CYCLES = 8,
  parameter int P_CNT_WIDTH      = 8
) (
  input logic              clk,
  input logic              reset,
  esl_fault_filter_if.slave bus
);

  localparam int P_MAX_CYCLES = (P_FILTER_CYCLES > P_RECOVER_CYCLES) ? P_FILTER_CYCLES : P_RECOVER_CYCLES;
  localparam int CW           = $clog2(P_MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULTED = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    enter_fault;
  logic                    clear_ok;
  logic [P_DATA_WIDTH-1:0] fault_bits_q;
  logic [P_CNT_WIDTH-1:0]  fault_count_q;

`ifdef ESL_FAULT_AUTO_RECOVER_EN
  logic unused_fault_clr;
  assign unused_fault_clr = bus.fault_clr;
  assign clear_ok         = 1'b1;
`else
  assign clear_ok = bus.fault_clr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt is shared: faulty-sample run in PENDING, clean-sample run in RECOVER.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    enter_fault = 1'b0;
    case (state_q)
      ST_OK: begin
        if (bus.fault_in) begin
          if (P_FILTER_CYCLES == 1) begin
            state_d     = ST_FAULTED;
            enter_fault = 1'b1;
            cnt_d       = '0;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_PENDING: begin
        if (!bus.fault_in) begin
          state_d = ST_OK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(P_FILTER_CYCLES - 1)) begin
          state_d     = ST_FAULTED;
          enter_fault = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FAULTED: begin
        if (clear_ok && !bus.fault_in) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end
      end
      ST_RECOVER: begin
        if (bus.fault_in) begin
          state_d     = ST_FAULTED;
          enter_fault = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == CW'(P_RECOVER_CYCLES - 1)) begin
          state_d = ST_OK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_OK;
        cnt_d   = '0;
      end
    endcase
  end

  // Statistics update only on entry into FAULTED; the bitmap survives recovery.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_bits_q  <= '0;
      fault_count_q <= '0;
    end else if (enter_fault) begin
      fault_bits_q <= ~bus.check_ok;
      if (fault_count_q != {P_CNT_WIDTH{1'b1}}) begin
        fault_count_q <= fault_count_q + P_CNT_WIDTH'(1);
      end
    end
  end

  assign bus.state         = state_q;
  assign bus.safe_ok       = ~state_q[1];
  assign bus.fault_latched = state_q[1];
  assign bus.fault_bits    = fault_bits_q;
  assign bus.fault_count   = fault_count_q;

endmodule

// File: tb/tb_esl_fault_filter.sv
// Bench for esl_fault_filter: two instances (8-bit and 2-bit entry counters) driven in
// lockstep and compared against a run-length reference model; honours ESL_FAULT_AUTO_RECOVER_EN.
module tb_esl_fault_filter;

  localparam int W = 7;
  localparam int F = 4;
  localparam int R = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  esl_fault_filter_if #(.P_DATA_WIDTH(W), .P_CNT_WIDTH(8)) bus_a ();
  esl_fault_filter_if #(.P_DATA_WIDTH(W), .P_CNT_WIDTH(2)) bus_b ();

  esl_fault_filter #(.P_DATA_WIDTH(W), .P_FILTER_CYCLES(F), .P_RECOVER_CYCLES(R), .P_CNT_WIDTH(8))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  esl_fault_filter #(.P_DATA_WIDTH(W), .P_FILTER_CYCLES(F), .P_RECOVER_CYCLES(R), .P_CNT_WIDTH(2))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts consecutive faulty / clean samples rather than tracking states.
  bit         m_latched;
  bit         m_recovering;
  int         m_fault_run;
  int         m_clean_run;
  logic [W-1:0] m_bits;
  int         m_count_a;
  int         m_count_b;

  function automatic void model_reset();
    m_latched    = 0;
    m_recovering = 0;
    m_fault_run  = 0;
    m_clean_run  = 0;
    m_bits       = '0;
    m_count_a    = 0;
    m_count_b    = 0;
  endfunction

  function automatic void model_enter_fault(input logic [W-1:0] ck);
    m_latched    = 1;
    m_recovering = 0;
    m_fault_run  = 0;
    m_bits       = ~ck;
    m_count_a    = (m_count_a + 1 > 255) ? 255 : m_count_a + 1;
    m_count_b    = (m_count_b + 1 > 3) ? 3 : m_count_b + 1;
  endfunction

  function automatic void model_step(input logic fi, input logic fc, input logic [W-1:0] ck);
    bit clr_ok;
`ifdef ESL_FAULT_AUTO_RECOVER_EN
    clr_ok = 1;
`else
    clr_ok = fc;
`endif
    if (!m_latched) begin
      if (fi) begin
        m_fault_run++;
        if (m_fault_run >= F) model_enter_fault(ck);
      end else begin
        m_fault_run = 0;
      end
    end else if (!m_recovering) begin
      if (!fi && clr_ok) begin
        m_recovering = 1;
        m_clean_run  = 0;
      end
    end else begin
      if (fi) begin
        model_enter_fault(ck);
      end else begin
        m_clean_run++;
        if (m_clean_run >= R) begin
          m_latched    = 0;
          m_recovering = 0;
          m_fault_run  = 0;
        end
      end
    end
  endfunction

  function automatic int model_state();
    if (m_latched) return m_recovering ? 3 : 2;
    return (m_fault_run > 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " a.state"},       32'(bus_a.state),         32'(model_state()));
    check({tag, " a.safe_ok"},     32'(bus_a.safe_ok),       32'(!m_latched));
    check({tag, " a.latched"},     32'(bus_a.fault_latched), 32'(m_latched));
    check({tag, " a.fault_bits"},  32'(bus_a.fault_bits),    32'(m_bits));
    check({tag, " a.fault_count"}, 32'(bus_a.fault_count),   32'(m_count_a));
    check({tag, " b.state"},       32'(bus_b.state),         32'(model_state()));
    check({tag, " b.fault_count"}, 32'(bus_b.fault_count),   32'(m_count_b));
  endtask

  task automatic applyStimulus(input string tag, input logic fi, input logic fc, input logic [W-1:0] ck);
    @(negedge clk);
    bus_a.fault_in  = fi;
    bus_a.fault_clr = fc;
    bus_a.check_ok  = ck;
    bus_b.fault_in  = fi;
    bus_b.fault_clr = fc;
    bus_b.check_ok  = ck;
    @(posedge clk);
    model_step(fi, fc, ck);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int entries_before;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus_a.fault_in = 1'b0; bus_a.fault_clr = 1'b0; bus_a.check_ok = '1;
    bus_b.fault_in = 1'b0; bus_b.fault_clr = 1'b0; bus_b.check_ok = '1;
    model_reset();
    #12;
    checkOutput("reset");
    check("reset cnt", 32'(dut_a.cnt_q), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] glitch rejection");
    repeat (3) applyStimulus("glitch_hi", 1'b1, 1'b0, 7'b1111110);
    check("glitch pending", 32'(bus_a.state), 32'd1);
    applyStimulus("glitch_lo", 1'b0, 1'b0, '1);
    check("glitch ok", 32'(bus_a.state), 32'd0);
    check("glitch count", 32'(bus_a.fault_count), 32'd0);

    $display("[TB] latch");
    repeat (3) applyStimulus("latch_pre", 1'b1, 1'b0, 7'b1111011);
    check("latch not yet", 32'(bus_a.fault_latched), 32'd0);
    applyStimulus("latch_edge", 1'b1, 1'b0, 7'b1111011);
    check("latch latched", 32'(bus_a.fault_latched), 32'd1);
    check("latch bits", 32'(bus_a.fault_bits), 32'h04);
    check("latch count", 32'(bus_a.fault_count), 32'd1);

    $display("[TB] clear rejected then release");
    applyStimulus("clr_rejected", 1'b1, 1'b1, 7'b0000000);
    check("clr rejected state", 32'(bus_a.state), 32'd2);
    check("clr rejected bits", 32'(bus_a.fault_bits), 32'h04);
    applyStimulus("clr_accept", 1'b0, 1'b1, '1);
    check("clr recover", 32'(bus_a.state), 32'd3);
    repeat (R - 1) applyStimulus("release_wait", 1'b0, 1'b0, '1);
    check("release not yet", 32'(bus_a.safe_ok), 32'd0);
    applyStimulus("release_edge", 1'b0, 1'b0, '1);
    check("release safe", 32'(bus_a.safe_ok), 32'd1);
    applyStimulus("bits_kept", 1'b0, 1'b0, '1);
    check("bits kept in ok", 32'(bus_a.fault_bits), 32'h04);

    $display("[TB] recovery abort");
    repeat (F) applyStimulus("abort_latch", 1'b1, 1'b0, 7'b0111111);
    applyStimulus("abort_clr", 1'b0, 1'b1, '1);
    repeat (5) applyStimulus("abort_clean", 1'b0, 1'b0, '1);
    check("abort cnt5", 32'(dut_a.cnt_q), 32'd5);
    entries_before = int'(bus_a.fault_count);
    applyStimulus("abort_hit", 1'b1, 1'b0, 7'b1011111);
    check("abort faulted", 32'(bus_a.state), 32'd2);
    check("abort count", 32'(bus_a.fault_count), 32'(entries_before + 1));
    check("abort bits", 32'(bus_a.fault_bits), 32'h20);

    $display("[TB] saturation");
    for (int i = 0; i < 3; i++) begin
      applyStimulus("sat_clr", 1'b0, 1'b1, '1);
      applyStimulus("sat_hit", 1'b1, 1'b0, 7'(i));
    end
    check("sat count b", 32'(bus_b.fault_count), 32'd3);
    check("sat count a", 32'(bus_a.fault_count), 32'd6);

    $display("[TB] reset mid-recover");
    applyStimulus("rst_clr", 1'b0, 1'b1, '1);
    applyStimulus("rst_clean", 1'b0, 1'b0, '1);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_async");
    check("rst safe", 32'(bus_a.safe_ok), 32'd1);
    @(negedge clk);
    reset = 1'b1;

`ifdef ESL_FAULT_AUTO_RECOVER_EN
    $display("[TB] auto recover");
    repeat (F) applyStimulus("auto_latch", 1'b1, 1'b0, 7'b1111101);
    applyStimulus("auto_release", 1'b0, 1'b0, '1);
    check("auto recover", 32'(bus_a.state), 32'd3);
`endif

    $display("[TB] randomized phase");
    for (int seg = 0; seg < 24; seg++) begin
      int bias;
      case (seg % 4)
        0: bias = 5;
        1: bias = 95;
        2: bias = 50;
        default: bias = 80;
      endcase
      for (int c = 0; c < 20; c++) begin
        applyStimulus("random", ($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0, W'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
